// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// The main entry drives out_*. The skid entry catches one item that arrives while
// main is held, which keeps in_ready a plain flop output.
// Synchronous flush squashes both entries. out_ctrl is masked to 0 on bubbles.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
// Without that macro, stall_cnt and flush_cnt are tied to 0.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              pop;

    // in_ready depends only on the skid flop, so there is no path from out_ready.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign pop       = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    // Storage update: flush voids any same-cycle accept/pop; skid drains into main on pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (pop) begin
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
            end
        end else begin
            if (accept && (pop || !main_valid)) begin
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
                main_valid <= 1'b1;
            end else if (accept) begin
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
                skid_valid <= 1'b1;
            end else if (pop) begin
                main_valid <= 1'b0;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating statistics counters; a flush does not clear them, only rst does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a queue-based reference model plus directed and random stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [63:0] s_out_data;
    logic [7:0]  s_out_ctrl;
    logic [1:0]  s_stall_cnt;
    logic [1:0]  s_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Reference model: the stage is a FIFO of at most two items; the head is what out_* shows.
    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
    } item_t;

    item_t q[$];
    int    m_stalls = 0;
    int    m_flushes = 0;

    function automatic int exp_cnt(input int n, input int w);
`ifdef PIPE_STAGE_STATS_EN
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
`else
        return 0 * n * w;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            bit do_pop;
            bit do_acc;
            do_pop = (q.size() > 0) && out_ready;
            do_acc = in_valid && (q.size() < 2);
            if ((q.size() > 0) && !out_ready) m_stalls <= m_stalls + 1;
            if (flush) m_flushes <= m_flushes + 1;
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_acc) q.push_back('{d: in_data, c: in_ctrl});
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        m_valid;
        logic [7:0]  m_ctrl;
        m_valid = (q.size() > 0);
        m_ctrl  = m_valid ? q[0].c : 8'h00;
        chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("out_ctrl", {56'd0, out_ctrl}, {56'd0, m_ctrl});
        if (m_valid) chk("out_data", out_data, q[0].d);
        chk("stall_cnt", {48'd0, stall_cnt}, 64'(exp_cnt(m_stalls, 16)));
        chk("flush_cnt", {48'd0, flush_cnt}, 64'(exp_cnt(m_flushes, 16)));
        chk("s_out_valid", {63'd0, s_out_valid}, {63'd0, m_valid});
        chk("s_out_ctrl", {56'd0, s_out_ctrl}, {56'd0, m_ctrl});
        chk("s_stall_cnt", {62'd0, s_stall_cnt}, 64'(exp_cnt(m_stalls, 2)));
        chk("s_flush_cnt", {62'd0, s_flush_cnt}, 64'(exp_cnt(m_flushes, 2)));
    end

    task automatic step(input logic iv, input logic [63:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
        chk("rst_flush", {48'd0, flush_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Stream 1..8 at full rate: each item shows 1 cycle after accept.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'(i), 8'(i + 16), 1'b1, 1'b0);
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_data", out_data, 64'(i));
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
        end
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk("stream_drain", {63'd0, out_valid}, 64'd0);

        // Back-pressure: 0xA in main, 0xB in skid, then drain in order.
        step(1'b1, 64'hA, 8'h01, 1'b0, 1'b0);
        chk("bp_a_data", out_data, 64'hA);
        chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
        step(1'b1, 64'hB, 8'h02, 1'b0, 1'b0);
        chk("bp_b_hold", out_data, 64'hA);
        chk("bp_b_ready", {63'd0, in_ready}, 64'd0);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk("bp_pop_b", out_data, 64'hB);
        chk("bp_pop_ready", {63'd0, in_ready}, 64'd1);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Flush with both entries full and 0xC offered: nothing survives.
        step(1'b1, 64'h11, 8'h33, 1'b0, 1'b0);
        step(1'b1, 64'h22, 8'h44, 1'b0, 1'b0);
        step(1'b1, 64'hC, 8'h55, 1'b0, 1'b1);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("fl_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
            chk("fl_no_c", {63'd0, out_valid}, 64'd0);
        end

        // Control masking when the held entry is popped.
        step(1'b1, 64'h77, 8'hFF, 1'b0, 1'b0);
        chk("mask_held", {56'd0, out_ctrl}, 64'hFF);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        chk("mask_valid", {63'd0, out_valid}, 64'd0);
        chk("mask_ctrl", {56'd0, out_ctrl}, 64'd0);

        // Asynchronous reset with the skid full, between edges.
        step(1'b1, 64'h31, 8'h0F, 1'b0, 1'b0);
        step(1'b1, 64'h32, 8'hF0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_data", out_data, 64'd0);
        chk("arst_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("arst_stall", {48'd0, stall_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Statistics: 5 stalled cycles, 4 flushes.
        step(1'b1, 64'h5, 8'h1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
        chk("stats16_stall", {48'd0, stall_cnt}, 64'd5);
        chk("stats16_flush", {48'd0, flush_cnt}, 64'd4);
        chk("stats2_stall", {62'd0, s_stall_cnt}, 64'd3);
        chk("stats2_flush", {62'd0, s_flush_cnt}, 64'd3);
`else
        chk("stats16_stall", {48'd0, stall_cnt}, 64'd0);
        chk("stats16_flush", {48'd0, flush_cnt}, 64'd0);
        chk("stats2_stall", {62'd0, s_stall_cnt}, 64'd0);
        chk("stats2_flush", {62'd0, s_flush_cnt}, 64'd0);
`endif
        do_reset();

        // Random traffic checked cycle by cycle by the model.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 8'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
